// File: rtl/inst_buffer.sv
// Instruction buffer between IF1 and decode: circular FIFO taking up to four
// fetch entries per cycle and presenting the two oldest entries to decode.

module inst_buffer_chk #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    push_num,
    input  logic [1:0]    pop_num,
    input  logic [CW-1:0] can_push_size,
    input  logic [1:0]    out_valid
);
    logic [1:0] avail_s;

    assign avail_s = {1'b0, out_valid[1]} + {1'b0, out_valid[0]};

    // Flag IF1 pushing beyond free space and decode popping beyond visible entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (CW'(push_num) <= can_push_size)
                else $warning("inst_buffer: push_num %0d exceeds free slots %0d", push_num, can_push_size);
            assert (pop_num <= avail_s)
                else $warning("inst_buffer: pop_num %0d exceeds visible entries %0d", pop_num, avail_s);
        end
    end
endmodule

module inst_buffer #(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WD    = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [4*DATA_WD-1:0]    push_data,
    input  logic [2:0]              push_num,
    output logic [DEPTH_LOG2:0]     can_push_size,
    output logic [2*DATA_WD-1:0]    out_data,
    output logic [1:0]              out_valid,
    input  logic [1:0]              pop_num,
    output logic                    empty,
    output logic                    full
);
    localparam int CW = DEPTH_LOG2 + 1;

    logic [DATA_WD-1:0]    mem_q [DEPTH];
    logic [DATA_WD-1:0]    mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0]         free_s;
    logic [CW-1:0]         push_ext_s;
    logic [CW-1:0]         pop_ext_s;
    logic [CW-1:0]         eff_push_s;
    logic [CW-1:0]         eff_pop_s;

    assign can_push_size = free_s;
    assign out_valid     = {count_q >= CW'(2), count_q >= CW'(1)};
    assign empty         = (count_q == CW'(0));
    assign full          = (count_q == CW'(DEPTH));
    assign out_data      = {mem_q[head_q + DEPTH_LOG2'(1)], mem_q[head_q]};

    // Clamp requests against start-of-cycle occupancy and compute next pointers/storage.
    always_comb begin
        free_s     = CW'(DEPTH) - count_q;
        push_ext_s = CW'(push_num);
        pop_ext_s  = CW'(pop_num);
        eff_push_s = (push_ext_s > free_s) ? free_s : push_ext_s;
        eff_pop_s  = (pop_ext_s > count_q) ? count_q : pop_ext_s;
        mem_d      = mem_q;

        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Eff counts are at most 4, so truncation to pointer width still wraps correctly.
            head_d  = head_q + eff_pop_s[DEPTH_LOG2-1:0];
            tail_d  = tail_q + eff_push_s[DEPTH_LOG2-1:0];
            count_d = count_q + eff_push_s - eff_pop_s;
            for (int k = 0; k < 4; k++) begin
                if (CW'(k) < eff_push_s) begin
                    mem_d[tail_q + DEPTH_LOG2'(k)] = push_data[k*DATA_WD +: DATA_WD];
                end else begin
                    mem_d[tail_q + DEPTH_LOG2'(k)] = mem_q[tail_q + DEPTH_LOG2'(k)];
                end
            end
        end
    end

    // State update; reset and flush are already folded into the next-state values.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        mem_q   <= mem_d;
    end

    inst_buffer_chk #(.CW(CW)) u_chk (
        .clk           (clk),
        .rst           (rst),
        .push_num      (push_num),
        .pop_num       (pop_num),
        .can_push_size (can_push_size),
        .out_valid     (out_valid)
    );
endmodule
